gpr_writeback: RTL and testbench
================================

Name: gpr_writeback

Overview:
- Architectural general-purpose register file and writeback stage; the write-side counterpart of operand decode.
- Accepts retired results over a valid/ready handshake, buffers one commit, then applies it to EAX..EDI.
- Applies x86 partial-register rules (8-bit low/high, 16-bit, 32-bit) and exports the eight 32-bit register values that feed operand decode.

Parameters:
- ESP_RESET, 32'h0000_0000, reset value of ESP. All other GPRs reset to 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_valid  in  1  commit offered.
- wb_ready  out  1  commit accepted this cycle when wb_valid && wb_ready.
- a_en  in  1  port A (explicit opnd0 destination) writes.
- a_sel  in  3  port A register selector, encoded as REG_EAX..REG_EDI.
- a_1byte  in  1  port A 8-bit write. Selectors 0-3 target AL/CL/DL/BL; 4-7 target AH/CH/DH/BH.
- a_16bit  in  1  port A 16-bit write to bits 15:0. Ignored when a_1byte is set.
- a_data  in  32  port A data, right-aligned.
- b_en  in  1  port B (implicit destination, e.g. ESP or EDX) writes.
- b_sel  in  3  port B selector. Port B always writes 32 bits.
- b_data  in  32  port B data.
- stall  in  1  blocks applying the buffered commit.
- eax, ecx, edx, ebx, esp, ebp, esi, edi  out  32 each  architectural register values.
- pending  out  1  a buffered commit is waiting to apply.
- retire_count  out  32  number of commits applied.

Behaviour:
- Reset (asynchronous, rst_n low):
  - all GPRs = 0, except esp = ESP_RESET;
  - pending = 0; retire_count = 0;
  - any buffered commit is discarded.
- FSM has two states, derived from pending:
  - EMPTY: wb_ready = 1. On accept, latch {a_*, b_*} into the buffer and go to FULL.
  - FULL: when stall = 0, apply the buffer at this edge.
    - If wb_valid is also high in the same cycle, accept the new commit into the buffer and stay FULL. This gives back-to-back throughput of 1 per cycle.
    - Otherwise go to EMPTY.
  - FULL with stall = 1: hold the buffer; wb_ready = 0.
  - wb_ready = ~pending | ~stall. It is combinational and must not depend on wb_valid.
- Latency:
  - A commit accepted at edge N becomes visible on the register outputs after edge N+1, given stall = 0 in cycle N+1.
  - There is no bypass: register outputs always show architectural state only.
- Apply order within one commit: port B is applied first, then port A is merged on top.
  - Same register, port A 32-bit: A wins entirely.
  - Same register, port A partial: A's lanes come from A, the remaining lanes come from b_data.
  - Different registers: both are written independently.
- Byte-lane merge for port A, with target reg R and old value O:
  - 8-bit, sel 0-3: R = {O[31:8], a_data[7:0]}.
  - 8-bit, sel 4-7: the target is GPR (sel-4), and R = {O[31:16], a_data[7:0], O[7:0]}.
  - 16-bit: R = {O[31:16], a_data[15:0]}.
  - 32-bit: R = a_data.
  - Here O is the value after port B has been applied.
- A commit with a_en = b_en = 0 is still accepted and still counts as retired.
- retire_count increments by 1 on every apply and wraps from 32'hFFFF_FFFF to 0.
- wb_valid low while the block is EMPTY: no state change.

Decomposition:
- Shared constants belong in defines.v:
  - REG_EAX..REG_EDI selector encodings (0 = EAX, 1 = ECX, 2 = EDX, 3 = EBX, 4 = ESP, 5 = EBP, 6 = ESI, 7 = EDI);
  - a 2-bit width code WB_W8 / WB_W16 / WB_W32, used internally after the a_1byte/a_16bit priority.
- Sub-module gpr_wb_merge: combinational. Inputs are old value, data, width code and high-byte flag; output is the merged 32-bit value. It is instantiated once per GPR, or once for port A with the result steered by a decoded selector.

Test Plan:
- Reset mid-operation: accept a commit with a_sel = ECX, a_data = 32'h1234_5678, and stall = 1; drop rst_n to 0. Required: pending = 0, ecx = 0, esp = ESP_RESET, and the commit is never applied after reset is released.
- Partial writes: eax = 32'hAABB_CCDD.
  - Write a_sel = 4 with a_1byte and a_data = 8'h11: required eax = 32'hAABB_11DD.
  - Then a_16bit with a_data = 16'h2233: required eax = 32'hAABB_2233.
- Port collision: b_sel = EAX with b_data = 32'hFFFF_FFFF, plus a_sel = EAX with a_1byte and a_data = 8'h00. Required: eax = 32'hFFFF_FF00.
  - Then a 32-bit port A write of 32'h5 with port B writing 32'h9 to EAX: required eax = 32'h5.
- Back-to-back throughput: offer 4 commits on consecutive cycles with stall = 0. Required: wb_ready stays 1, the results are visible in cycles N+1..N+4, and retire_count = 4.
- Stall backpressure: buffer a commit, then hold stall = 1 for 3 cycles with wb_valid high. Required: wb_ready = 0 and registers unchanged during those 3 cycles; on the first cycle after stall falls, one apply and one accept occur.
- Counter wrap: force retire_count to 32'hFFFF_FFFF, then apply one empty commit. Required: retire_count = 0 and registers unchanged.

Source files
------------

// File: rtl/gpr_writeback_pkg.sv
// Shared types for the GPR writeback stage: register selectors, port A
// width codes and the buffered commit record.
package gpr_writeback_pkg;

    typedef enum logic [2:0] {
        REG_EAX = 3'd0,
        REG_ECX = 3'd1,
        REG_EDX = 3'd2,
        REG_EBX = 3'd3,
        REG_ESP = 3'd4,
        REG_EBP = 3'd5,
        REG_ESI = 3'd6,
        REG_EDI = 3'd7
    } reg_sel_e;

    typedef enum logic [1:0] {
        WB_W8  = 2'd0,
        WB_W16 = 2'd1,
        WB_W32 = 2'd2
    } wb_width_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } wb_state_e;

    localparam int unsigned NUM_GPR = 8;

    // One retired result, with port A already resolved to target/width/lane
    typedef struct packed {
        logic        a_en;
        reg_sel_e    a_tgt;
        wb_width_e   a_width;
        logic        a_high;
        logic [31:0] a_data;
        logic        b_en;
        reg_sel_e    b_sel;
        logic [31:0] b_data;
    } wb_cmd_t;

    // The byte flag takes priority over the 16-bit flag
    function automatic wb_width_e wb_width_of(input logic one_byte, input logic sixteen);
        if (one_byte) begin
            return WB_W8;
        end else if (sixteen) begin
            return WB_W16;
        end
        return WB_W32;
    endfunction

    // Byte writes with selectors 4-7 land in AH/CH/DH/BH of GPR (sel-4)
    function automatic reg_sel_e wb_target_of(input logic [2:0] sel, input logic one_byte);
        if (one_byte) begin
            return reg_sel_e'({1'b0, sel[1:0]});
        end
        return reg_sel_e'(sel);
    endfunction

endpackage

// File: rtl/gpr_wb_merge.sv
// Byte-lane merge of a right-aligned write into an existing 32-bit register.
module gpr_wb_merge
    import gpr_writeback_pkg::*;
(
    input  logic [31:0] old_val,
    input  logic [31:0] data,
    input  wb_width_e   width,
    input  logic        high_byte,
    output logic [31:0] merged
);

    // Select which lanes come from the new data
    always_comb begin
        merged = old_val;
        case (width)
            WB_W8: begin
                if (high_byte) begin
                    merged = {old_val[31:16], data[7:0], old_val[7:0]};
                end else begin
                    merged = {old_val[31:8], data[7:0]};
                end
            end
            WB_W16:  merged = {old_val[31:16], data[15:0]};
            WB_W32:  merged = data;
            default: merged = old_val;
        endcase
    end

endmodule

// File: rtl/gpr_writeback.sv
// Architectural GPR file and writeback stage: one-entry commit buffer with
// valid/ready intake, stall-gated apply, and x86 partial-register merging.
module gpr_writeback
    import gpr_writeback_pkg::*;
#(
    parameter logic [31:0] ESP_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic        a_en,
    input  logic [2:0]  a_sel,
    input  logic        a_1byte,
    input  logic        a_16bit,
    input  logic [31:0] a_data,
    input  logic        b_en,
    input  logic [2:0]  b_sel,
    input  logic [31:0] b_data,
    input  logic        stall,
    output logic [31:0] eax,
    output logic [31:0] ecx,
    output logic [31:0] edx,
    output logic [31:0] ebx,
    output logic [31:0] esp,
    output logic [31:0] ebp,
    output logic [31:0] esi,
    output logic [31:0] edi,
    output logic        pending,
    output logic [31:0] retire_count
);

    wb_state_e   state_q, state_d;
    wb_cmd_t     buf_q, buf_d;
    logic [31:0] retire_count_q, retire_count_d;
    logic [31:0] gpr_q [NUM_GPR];
    logic [31:0] gpr_d [NUM_GPR];

    logic        accept;
    logic        apply;
    logic [31:0] a_old;
    logic [31:0] a_merged;

    // Handshake: a full buffer frees its slot on the same edge it applies
    always_comb begin
        pending  = (state_q == ST_FULL);
        wb_ready = ~pending | ~stall;
        accept   = wb_valid & wb_ready;
        apply    = pending & ~stall;
    end

    // Port A merges on top of the post-port-B value of its target
    always_comb begin
        a_old = gpr_q[buf_q.a_tgt];
        if (buf_q.b_en && (buf_q.b_sel == buf_q.a_tgt)) begin
            a_old = buf_q.b_data;
        end
    end

    gpr_wb_merge u_merge_a (
        .old_val   (a_old),
        .data      (buf_q.a_data),
        .width     (buf_q.a_width),
        .high_byte (buf_q.a_high),
        .merged    (a_merged)
    );

    // Next buffer contents and FSM state
    always_comb begin
        buf_d   = buf_q;
        state_d = state_q;
        if (accept) begin
            buf_d.a_en    = a_en;
            buf_d.a_tgt   = wb_target_of(a_sel, a_1byte);
            buf_d.a_width = wb_width_of(a_1byte, a_16bit);
            buf_d.a_high  = a_1byte & a_sel[2];
            buf_d.a_data  = a_data;
            buf_d.b_en    = b_en;
            buf_d.b_sel   = reg_sel_e'(b_sel);
            buf_d.b_data  = b_data;
            state_d       = ST_FULL;
        end else if (apply) begin
            state_d = ST_EMPTY;
        end
    end

    // Next register file and retire counter: port B first, port A over it
    always_comb begin
        for (int unsigned i = 0; i < NUM_GPR; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        retire_count_d = retire_count_q;
        if (apply) begin
            if (buf_q.b_en) begin
                gpr_d[buf_q.b_sel] = buf_q.b_data;
            end
            if (buf_q.a_en) begin
                gpr_d[buf_q.a_tgt] = a_merged;
            end
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    // State registers; reset drops any buffered commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            buf_q          <= '0;
            retire_count_q <= '0;
            for (int unsigned i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= (i == 32'(REG_ESP)) ? ESP_RESET : '0;
            end
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            retire_count_q <= retire_count_d;
            for (int unsigned i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    // Architectural outputs
    always_comb begin
        eax          = gpr_q[REG_EAX];
        ecx          = gpr_q[REG_ECX];
        edx          = gpr_q[REG_EDX];
        ebx          = gpr_q[REG_EBX];
        esp          = gpr_q[REG_ESP];
        ebp          = gpr_q[REG_EBP];
        esi          = gpr_q[REG_ESI];
        edi          = gpr_q[REG_EDI];
        retire_count = retire_count_q;
    end

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed testbench for gpr_writeback with hand-computed expectations.
module tb_gpr_writeback;

    localparam logic [31:0] ESP_RST = 32'h0000_FFF0;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic        a_en;
    logic [2:0]  a_sel;
    logic        a_1byte;
    logic        a_16bit;
    logic [31:0] a_data;
    logic        b_en;
    logic [2:0]  b_sel;
    logic [31:0] b_data;
    logic        stall;
    logic [31:0] eax, ecx, edx, ebx, esp, ebp, esi, edi;
    logic        pending;
    logic [31:0] retire_count;

    int unsigned total;
    int unsigned bad;

    gpr_writeback #(.ESP_RESET(ESP_RST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .a_en         (a_en),
        .a_sel        (a_sel),
        .a_1byte      (a_1byte),
        .a_16bit      (a_16bit),
        .a_data       (a_data),
        .b_en         (b_en),
        .b_sel        (b_sel),
        .b_data       (b_data),
        .stall        (stall),
        .eax          (eax),
        .ecx          (ecx),
        .edx          (edx),
        .ebx          (ebx),
        .esp          (esp),
        .ebp          (ebp),
        .esi          (esi),
        .edi          (edi),
        .pending      (pending),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic ae, input logic [2:0] as, input logic a1, input logic a16,
                         input logic [31:0] ad, input logic be, input logic [2:0] bs,
                         input logic [31:0] bd);
        wb_valid = 1'b1;
        a_en     = ae;
        a_sel    = as;
        a_1byte  = a1;
        a_16bit  = a16;
        a_data   = ad;
        b_en     = be;
        b_sel    = bs;
        b_data   = bd;
    endtask

    task automatic idle();
        wb_valid = 1'b0;
        a_en     = 1'b0;
        b_en     = 1'b0;
    endtask

    // Offer at a negedge, accept on the next posedge, apply on the one after
    task automatic commit_one(input logic ae, input logic [2:0] as, input logic a1, input logic a16,
                              input logic [31:0] ad, input logic be, input logic [2:0] bs,
                              input logic [31:0] bd);
        offer(ae, as, a1, a16, ad, be, bs, bd);
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        a_sel    = 3'd0;
        a_1byte  = 1'b0;
        a_16bit  = 1'b0;
        a_data   = '0;
        b_sel    = 3'd0;
        b_data   = '0;
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("rst_eax", eax, 32'h0);
        chk("rst_esp", esp, ESP_RST);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_retire", retire_count, 32'd0);
        chk("rst_ready", {31'd0, wb_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Partial-register writes
        offer(1'b1, 3'd0, 1'b0, 1'b0, 32'hAABB_CCDD, 1'b0, 3'd0, 32'h0);
        @(negedge clk);
        idle();
        chk("buf_pending", {31'd0, pending}, 32'd1);
        chk("no_bypass", eax, 32'h0);
        @(negedge clk);
        chk("load_eax", eax, 32'hAABB_CCDD);
        chk("load_pending", {31'd0, pending}, 32'd0);
        commit_one(1'b1, 3'd4, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 3'd0, 32'h0);
        chk("ah_write", eax, 32'hAABB_11DD);
        chk("ah_esp_untouched", esp, ESP_RST);
        commit_one(1'b1, 3'd0, 1'b0, 1'b1, 32'h0000_2233, 1'b0, 3'd0, 32'h0);
        chk("ax_write", eax, 32'hAABB_2233);
        commit_one(1'b1, 3'd3, 1'b1, 1'b1, 32'hDEAD_BE42, 1'b0, 3'd0, 32'h0);
        chk("bl_byte_priority", ebx, 32'h0000_0042);

        // Port A/B collisions and independent writes
        commit_one(1'b1, 3'd0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 3'd0, 32'hFFFF_FFFF);
        chk("collide_byte", eax, 32'hFFFF_FF00);
        commit_one(1'b1, 3'd0, 1'b0, 1'b0, 32'h0000_0005, 1'b1, 3'd0, 32'h0000_0009);
        chk("collide_32", eax, 32'h0000_0005);
        commit_one(1'b1, 3'd1, 1'b0, 1'b0, 32'h0000_0077, 1'b1, 3'd2, 32'h0000_0088);
        chk("indep_ecx", ecx, 32'h0000_0077);
        chk("indep_edx", edx, 32'h0000_0088);
        chk("retire_7", retire_count, 32'd7);

        // Reset while a stalled commit is buffered
        stall = 1'b1;
        offer(1'b1, 3'd1, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 3'd0, 32'h0);
        @(negedge clk);
        idle();
        chk("stall_pending", {31'd0, pending}, 32'd1);
        chk("stall_ready", {31'd0, wb_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pending", {31'd0, pending}, 32'd0);
        chk("mid_rst_ecx", ecx, 32'h0);
        chk("mid_rst_esp", esp, ESP_RST);
        chk("mid_rst_retire", retire_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_ecx", ecx, 32'h0);
        chk("post_rst_retire", retire_count, 32'd0);

        // Back-to-back commits, one per cycle
        begin
            logic [31:0] seq [4];
            logic [31:0] got;
            seq[0] = 32'h1111_0001;
            seq[1] = 32'h2222_0002;
            seq[2] = 32'h3333_0003;
            seq[3] = 32'h4444_0004;
            for (int k = 0; k < 5; k++) begin
                if (k < 4) begin
                    offer(1'b1, 3'(k), 1'b0, 1'b0, seq[k], 1'b0, 3'd0, 32'h0);
                end else begin
                    idle();
                end
                @(negedge clk);
                if (k < 4) begin
                    chk($sformatf("b2b_ready_%0d", k), {31'd0, wb_ready}, 32'd1);
                end
                if (k == 0) begin
                    chk("b2b_no_bypass", eax, 32'h0);
                end else begin
                    case (k)
                        1: got = eax;
                        2: got = ecx;
                        3: got = edx;
                        default: got = ebx;
                    endcase
                    chk($sformatf("b2b_val_%0d", k - 1), got, seq[k - 1]);
                end
            end
            idle();
            @(negedge clk);
            chk("b2b_ebx", ebx, seq[3]);
            chk("b2b_retire", retire_count, 32'd4);
            chk("b2b_pending", {31'd0, pending}, 32'd0);
        end

        // Stall backpressure with a second commit waiting
        offer(1'b1, 3'd6, 1'b0, 1'b0, 32'h0000_A5A5, 1'b0, 3'd0, 32'h0);
        @(negedge clk);
        stall = 1'b1;
        offer(1'b1, 3'd7, 1'b0, 1'b0, 32'h0000_5A5A, 1'b0, 3'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_ready_%0d", k), {31'd0, wb_ready}, 32'd0);
            chk($sformatf("stall_esi_%0d", k), esi, 32'h0);
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        chk("unstall_ready", {31'd0, wb_ready}, 32'd1);
        @(negedge clk);
        idle();
        chk("unstall_esi", esi, 32'h0000_A5A5);
        chk("unstall_edi_held", edi, 32'h0);
        chk("unstall_pending", {31'd0, pending}, 32'd1);
        chk("unstall_retire", retire_count, 32'd5);
        @(negedge clk);
        chk("second_edi", edi, 32'h0000_5A5A);
        chk("second_retire", retire_count, 32'd6);

        // Retire counter wrap on an empty commit
        force dut.retire_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retire_count_q;
        @(negedge clk);
        chk("wrap_preset", retire_count, 32'hFFFF_FFFF);
        commit_one(1'b0, 3'd0, 1'b0, 1'b0, 32'hDEAD_DEAD, 1'b0, 3'd0, 32'hBEEF_BEEF);
        chk("wrap_retire", retire_count, 32'h0);
        chk("wrap_eax", eax, 32'h1111_0001);
        chk("wrap_esp", esp, ESP_RST);
        chk("wrap_edi", edi, 32'h0000_5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
